// File: rtl/rr_arb8.sv
// rr_arb8 -- 8-requester round-robin arbiter with registered one-hot grant.
// A grant is held while its requester keeps asking and E stays high; on
// release the search pointer moves to the slot after the released owner.
// Optional feature: define RR_ARB8_TIMEOUT_EN to revoke a grant after
// MAX_HOLD consecutive cycles and pulse TOUT; otherwise TOUT is tied 0.
module rr_arb8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       E,
   input  logic [7:0] REQ,
   output logic [7:0] GNT,
   output logic [2:0] GID,
   output logic       VALID,
   output logic       TOUT
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] ptr;
   logic [2:0] ptr_nxt;
   logic [7:0] gnt_nxt;
   logic [2:0] gid_nxt;
   logic       valid_nxt;
   logic       tout_nxt;
   logic       win_found;
   logic [2:0] win_id;
   logic [2:0] scan_idx;
   logic       timeout;

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
      $error("rr_arb8: MAX_HOLD must lie in 2..255");
   end

`ifdef RR_ARB8_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hcnt;

   // Hold counter: zero while idle (so it starts at 0 on the grant edge), saturating count while busy
   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt <= '0;
      end else if (state == IDLE) begin
         hcnt <= '0;
      end else if (hcnt != 8'hFF) begin
         hcnt <= hcnt + 8'd1;
      end
   end

   // Timeout only applies to an owner that is still legitimately holding the grant
   always_comb begin
      timeout = (state == BUSY) && E && REQ[GID] && (hcnt == HOLD_LAST);
   end
`else
   assign timeout = 1'b0;
`endif

   // Winner search: first set request bit scanning upward from ptr, modulo 8
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         scan_idx = ptr + 3'(i);
         if (!win_found && REQ[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   // State and registered outputs; reset overrides every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         GNT   <= '0;
         GID   <= '0;
         VALID <= 1'b0;
         TOUT  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         GNT   <= gnt_nxt;
         GID   <= gid_nxt;
         VALID <= valid_nxt;
         TOUT  <= tout_nxt;
      end
   end

   // Next-state: grant on any enabled request, release on drop, disable or timeout
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (E && win_found) state_nxt = BUSY;
         end
         BUSY: begin
            if (!E || !REQ[GID] || timeout) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output/pointer next values; a release always costs one idle cycle before the next grant
   always_comb begin
      gnt_nxt   = '0;
      gid_nxt   = '0;
      valid_nxt = 1'b0;
      tout_nxt  = 1'b0;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (state_nxt == BUSY) begin
               gnt_nxt   = 8'b1 << win_id;
               gid_nxt   = win_id;
               valid_nxt = 1'b1;
            end
         end
         BUSY: begin
            if (state_nxt == BUSY) begin
               gnt_nxt   = GNT;
               gid_nxt   = GID;
               valid_nxt = 1'b1;
            end else begin
               ptr_nxt  = GID + 3'd1;
               tout_nxt = timeout;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum consecutive grant cycles per owner (valid range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 E  input  1  arbiter enable; low blocks new grants and revokes the current grant.
REQ-005 REQ  input  8  request vector; bit n = requester n.
REQ-006 GNT  output  8  one-hot grant, registered.
REQ-007 GID  output  3  binary index of the granted requester (8-to-3 encode of GNT), registered.
REQ-008 VALID  output  1  high while any grant is held, registered.
REQ-009 TOUT  output  1  one-cycle pulse when a grant is revoked by timeout (RR_ARB8_TIMEOUT_EN only; else tied 0).

Function
REQ-010 The FSM SHALL have two states: IDLE (no grant) and BUSY (grant held).
REQ-011 IDLE->BUSY when E=1 and REQ!=0; the winner is the first set REQ bit searching upward from PTR (mod 8).
REQ-012 On IDLE->BUSY, GNT, GID and VALID SHALL update in the same edge: one-cycle latency from REQ sampled to GNT visible.
REQ-013 In BUSY, GNT/GID SHALL hold constant while REQ[GID]=1 and E=1.
REQ-014 BUSY->IDLE when REQ[GID]=0 or E=0; GNT=0, GID=0, VALID=0 on that edge.
REQ-015 On every BUSY->IDLE transition PTR SHALL load GID+1 (3-bit wrap: 7->0).
REQ-016 After release, at least one IDLE cycle SHALL occur before the next grant (no back-to-back grant edges).
REQ-017 GNT SHALL never have more than one bit set; GID SHALL always equal the encoded GNT; VALID = |GNT.
REQ-018 Requests on bits other than GID during BUSY SHALL be ignored until the next IDLE.
REQ-019 REQ=0 in IDLE: remain IDLE, PTR unchanged.
REQ-020 Simultaneous release of REQ[GID] and E=0: single BUSY->IDLE, PTR advanced once.
REQ-021 Hold counter HCNT (8 bits) SHALL clear on IDLE->BUSY and increment each BUSY cycle, saturating at 255.

Reset
REQ-022 rst=1 at a clock edge SHALL force state IDLE, GNT=0, GID=0, VALID=0, TOUT=0, PTR=0, HCNT=0, overriding all other inputs.
REQ-023 Reset asserted mid-grant SHALL drop GNT on that same edge; no PTR advance.
REQ-024 First edge with rst=0 SHALL perform normal IDLE arbitration from PTR=0.

Configuration
REQ-025 Macro RR_ARB8_TIMEOUT_EN defined: when HCNT reaches MAX_HOLD-1 in BUSY with REQ[GID] still 1, next edge SHALL force BUSY->IDLE, advance PTR per REQ-015, pulse TOUT for one cycle.
REQ-026 Macro RR_ARB8_TIMEOUT_EN undefined: no timeout; grants held indefinitely; TOUT constant 0; HCNT may be omitted.

Verification
REQ-027 Reset then E=1, REQ=8'h00 for 5 cycles -> GNT=0, VALID=0, PTR=0 throughout.
REQ-028 E=1, REQ=8'b1000_0001 held -> cycle+1 GNT=8'h01 GID=0; drop REQ[0] -> GNT=0; next grant GNT=8'h80 GID=7.
REQ-029 REQ=8'hFF held with each owner dropping after 3 cycles -> grant order GID 0,1,2,...,7,0 with one idle cycle between grants.
REQ-030 Grant active on GID=3, assert rst one cycle -> GNT=0 same edge; after release with REQ=8'hFF, grant to GID=0.
REQ-031 Grant GID=5 held, E driven 0 -> GNT=0 next edge, PTR=6; E=1 with REQ=8'b0010_0001 -> GID=0 granted (search 6,7,0).
REQ-032 RR_ARB8_TIMEOUT_EN defined, MAX_HOLD=4, REQ=8'h06 held -> GID=1 for 4 cycles, TOUT pulse, idle cycle, then GID=2; undefined -> GID=1 held forever.
